// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment driver.
// One shift per clock; the display word only changes on the completing edge.
module bin_to_bcd_display #(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 system_clock,
    input  logic                 cpu_rst_n,
    input  logic [BIN_WIDTH-1:0] bin_val,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          display_val
);

    localparam int          CNT_W     = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] OVF_LIMIT = 32'd99_999_999;
    localparam logic [31:0] SATURATED = 32'h9999_9999;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [31:0]          r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_pending;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;
    logic [31:0]          r_display;

    logic                 w_last;
    logic                 w_ovf_in;
    logic [31:0]          w_bin_wide;
    logic [31:0]          w_bcd_adj;
    logic [31:0]          w_bcd_shift;
    logic                 w_busy_next;
    logic                 w_done_next;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly into decimal.
    function automatic logic [31:0] dabble_adjust(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int k = 0; k < 8; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    assign w_bin_wide  = 32'(bin_val);
    assign w_ovf_in    = (w_bin_wide > OVF_LIMIT);
    assign w_last      = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1'b1));
    assign w_bcd_adj   = dabble_adjust(r_bcd);
    assign w_bcd_shift = (w_bcd_adj << 1'b1) | {31'd0, r_bin[BIN_WIDTH-1]};

    // State register.
    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode, registered below so busy/done are glitch-free.
    always_comb begin
        w_busy_next = (w_state_next == ST_SHIFT);
        w_done_next = w_last;
    end

    // Conversion datapath: capture on accept, shift while converting; starts in SHIFT are ignored.
    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_bin         <= '0;
            r_bcd         <= 32'h0000_0000;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_bin         <= bin_val;
                r_bcd         <= 32'h0000_0000;
                r_cnt         <= CNT_W'(BIN_WIDTH);
                r_ovf_pending <= w_ovf_in;
            end else begin
                r_bin         <= r_bin;
                r_bcd         <= r_bcd;
                r_cnt         <= r_cnt;
                r_ovf_pending <= r_ovf_pending;
            end
        end else begin
            r_bin         <= r_bin << 1'b1;
            r_bcd         <= w_bcd_shift;
            r_cnt         <= r_cnt - CNT_W'(1'b1);
            r_ovf_pending <= r_ovf_pending;
        end
    end

    // Output registers: display/overflow move only on the completing edge.
    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_display  <= 32'h0000_0000;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            if (w_last) begin
                r_display  <= r_ovf_pending ? SATURATED : w_bcd_shift;
                r_overflow <= r_ovf_pending;
            end else begin
                r_display  <= r_display;
                r_overflow <= r_overflow;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign display_val = r_display;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed bench for bin_to_bcd_display: expected display words are queued at start and
// checked when done pulses, against a divide/modulo decimal model.
module tb_bin_to_bcd_display;

    localparam int W = 27;

    logic          system_clock = 1'b0;
    logic          cpu_rst_n    = 1'b0;
    logic          start        = 1'b0;
    logic [W-1:0]  bin_val      = '0;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [31:0]   display_val;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] disp;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    bin_to_bcd_display #(.BIN_WIDTH(W)) dut (
        .system_clock (system_clock),
        .cpu_rst_n    (cpu_rst_n),
        .bin_val      (bin_val),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .display_val  (display_val)
    );

    always #5 system_clock = ~system_clock;

    function automatic logic [31:0] model(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        r = 32'h0000_0000;
        if (v > 32'd99_999_999) begin
            return 32'h9999_9999;
        end
        t = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge system_clock);
        #1;
    endtask

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.disp = model(v);
        e.ovf  = (v > 32'd99_999_999);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_disp"}, display_val, e.disp);
            check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
        end
    endtask

    // Cycles from now until done is seen (bounded), and busy-high cycles over that window.
    task automatic wait_done(output int lat, output int busy_hi);
        lat     = 0;
        busy_hi = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 60) begin
            tick;
            lat++;
            busy_hi += (busy === 1'b1) ? 1 : 0;
        end
    endtask

    task automatic convert(input int unsigned v, input string tag);
        int lat;
        int bh;
        bin_val = W'(v);
        start   = 1'b1;
        push_exp(v);
        tick;
        start = 1'b0;
        wait_done(lat, bh);
        check({tag, "_latency"}, lat, 32'd27);
        check({tag, "_busy_cycles"}, bh, 32'd27);
        pop_check(tag);
    endtask

    initial begin
        int lat;
        int bh;
        int cnt;

        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_disp", display_val, 32'h0000_0000);
        tick;
        cpu_rst_n = 1'b1;
        tick;

        convert(0, "zero");

        convert(12_345_678, "mid");
        check("mid_pattern", display_val, 32'h1234_5678);
        cnt = 0;
        repeat (100) begin
            tick;
            if (display_val !== 32'h1234_5678 || done !== 1'b0) cnt++;
        end
        check("mid_hold_100", cnt, 32'd0);

        convert(99_999_999, "max");
        convert(100_000_000, "ovf");

        // start re-asserted mid-conversion with a different value must be ignored
        bin_val = W'(255);
        start   = 1'b1;
        push_exp(255);
        tick;
        start = 1'b0;
        repeat (9) tick;
        bin_val = W'(77);
        start   = 1'b1;
        tick;
        start   = 1'b0;
        bin_val = '0;
        wait_done(lat, bh);
        check("busy_start_latency", lat, 32'd17);
        pop_check("busy_start");
        cnt = 0;
        repeat (40) begin
            tick;
            if (done === 1'b1) cnt++;
        end
        check("no_second_done", cnt, 32'd0);

        // start held high: one result every 28 cycles
        bin_val = W'(42);
        start   = 1'b1;
        push_exp(42);
        tick;
        wait_done(lat, bh);
        check("held0_latency", lat, 32'd27);
        pop_check("held0");
        for (int i = 1; i < 3; i++) begin
            push_exp(42);
            tick;
            wait_done(lat, bh);
            check("held_period", lat + 1, 32'd28);
            pop_check("held");
        end
        start = 1'b0;
        tick;
        check("held_stop_busy", {31'd0, busy}, 32'd0);

        // reset mid-conversion aborts without a done pulse
        bin_val = W'(87_654_321);
        start   = 1'b1;
        push_exp(87_654_321);
        tick;
        start = 1'b0;
        repeat (14) tick;
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_disp", display_val, 32'h0000_0000);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        sb.delete();
        cnt = 0;
        repeat (3) begin
            tick;
            if (done === 1'b1) cnt++;
        end
        cpu_rst_n = 1'b1;
        repeat (30) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("abort_no_activity", cnt, 32'd0);

        convert(5, "post_rst");
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
